// File: rtl/adpll_ctrl_gen2.sv
// ADPLL loop controller: binary-search acquisition, unit-step tracking, phase-lock qualify; `ADPLL_RELOCK_EN adds loss-of-lock relock.
// Latency: a request sampled on a phase_clk edge is visible on every (registered) output right after that edge.
// Backpressure: none; a request is sampled every cycle, and a both-high or both-low input holds all state.
module adpll_ctrl_gen2 #(
    parameter int CODE_W      = 7,
    parameter int STEP_INIT   = 2 ** (CODE_W - 2),
    parameter int STEP_RELOCK = 4,
    parameter int LOCK_CNT    = 8,
    parameter int RUN_MAX     = 6
) (
    input  logic              phase_clk,
    input  logic              reset,
    input  logic              p_up,
    input  logic              p_down,
    output logic [CODE_W-1:0] dco_code,
    output logic              freq_lock,
    output logic              phase_lock,
    output logic              polarity,
    output logic              lol,
    output logic [1:0]        state
);

    localparam logic [1:0] ST_ACQ    = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [CODE_W-1:0] CODE_MID    = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [CODE_W-1:0] STEP_INIT_C = STEP_INIT[CODE_W-1:0];
    localparam logic [CODE_W-1:0] STEP_RELK_C = STEP_RELOCK[CODE_W-1:0];
    localparam logic [CODE_W-1:0] STEP_ONE    = {{(CODE_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]        LOCK_LAST   = 8'(LOCK_CNT - 1);

    logic [CODE_W-1:0] step_q;
    logic              dir_q;
    logic              dir_none_q;
    logic [7:0]        rev_cnt_q;

    logic              req_vld;
    logic              is_rev;
    logic              is_same;
    logic              lol_hit;
    logic [CODE_W-1:0] step_half;
    logic [CODE_W-1:0] step_apply;
    logic [CODE_W:0]   code_sum;
    logic [CODE_W-1:0] code_inc;
    logic [CODE_W-1:0] code_dec;

    logic [CODE_W-1:0] code_nxt;
    logic [CODE_W-1:0] step_nxt;
    logic [1:0]        state_nxt;
    logic              freq_lock_nxt;
    logic              phase_lock_nxt;
    logic              polarity_nxt;
    logic              dir_nxt;
    logic              dir_none_nxt;
    logic [7:0]        rev_cnt_nxt;

    // dir_q is 1 for the last valid request being p_up (decrement).
    assign req_vld = p_up ^ p_down;
    assign is_rev  = req_vld && !dir_none_q && (p_up != dir_q);
    assign is_same = req_vld && !dir_none_q && (p_up == dir_q);

    // In ACQ a reversal halves the step and the halved value is applied on the same edge.
    assign step_half  = (step_q > STEP_ONE) ? {1'b0, step_q[CODE_W-1:1]} : STEP_ONE;
    assign step_apply = ((state == ST_ACQ) && is_rev) ? step_half : step_q;

    assign code_sum = {1'b0, dco_code} + {1'b0, step_apply};
    assign code_inc = code_sum[CODE_W] ? '1 : code_sum[CODE_W-1:0];
    assign code_dec = (dco_code < step_apply) ? '0 : (dco_code - step_apply);

    always_comb begin
        code_nxt       = dco_code;
        step_nxt       = step_q;
        state_nxt      = state;
        freq_lock_nxt  = freq_lock;
        phase_lock_nxt = phase_lock;
        polarity_nxt   = 1'b0;
        dir_nxt        = dir_q;
        dir_none_nxt   = dir_none_q;
        rev_cnt_nxt    = rev_cnt_q;
        if (lol_hit) begin
            // Relock leaves the code where tracking ran away to and restarts the search from there.
            state_nxt      = ST_ACQ;
            step_nxt       = STEP_RELK_C;
            freq_lock_nxt  = 1'b0;
            phase_lock_nxt = 1'b0;
            dir_none_nxt   = 1'b1;
            rev_cnt_nxt    = 8'd0;
        end else if (req_vld) begin
            code_nxt     = p_up ? code_dec : code_inc;
            dir_nxt      = p_up;
            dir_none_nxt = 1'b0;
            polarity_nxt = is_rev;
            case (state)
                ST_ACQ: begin
                    if (is_rev) begin
                        step_nxt = step_half;
                        if (step_half == STEP_ONE) begin
                            state_nxt     = ST_TRACK;
                            freq_lock_nxt = 1'b1;
                            rev_cnt_nxt   = 8'd0;
                        end
                    end
                end
                ST_TRACK: begin
                    if (is_rev) begin
                        if (rev_cnt_q == LOCK_LAST) begin
                            state_nxt      = ST_LOCKED;
                            phase_lock_nxt = 1'b1;
                            rev_cnt_nxt    = 8'd0;
                        end else begin
                            rev_cnt_nxt = rev_cnt_q + 8'd1;
                        end
                    end else begin
                        rev_cnt_nxt = 8'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge phase_clk or posedge reset) begin
        if (reset) begin
            dco_code   <= CODE_MID;
            step_q     <= STEP_INIT_C;
            state      <= ST_ACQ;
            freq_lock  <= 1'b0;
            phase_lock <= 1'b0;
            polarity   <= 1'b0;
            dir_q      <= 1'b0;
            dir_none_q <= 1'b1;
            rev_cnt_q  <= 8'd0;
        end else begin
            dco_code   <= code_nxt;
            step_q     <= step_nxt;
            state      <= state_nxt;
            freq_lock  <= freq_lock_nxt;
            phase_lock <= phase_lock_nxt;
            polarity   <= polarity_nxt;
            dir_q      <= dir_nxt;
            dir_none_q <= dir_none_nxt;
            rev_cnt_q  <= rev_cnt_nxt;
        end
    end

`ifdef ADPLL_RELOCK_EN
    localparam logic [7:0] RUN_LAST = 8'(RUN_MAX - 1);
    localparam logic [7:0] RUN_SAT  = 8'(RUN_MAX);

    logic [7:0] run_cnt_q;

    // The request that would bring run_cnt to RUN_MAX is consumed by the relock.
    assign lol_hit = is_same && (state != ST_ACQ) && (run_cnt_q == RUN_LAST);

    always_ff @(posedge phase_clk or posedge reset) begin
        if (reset) begin
            run_cnt_q <= 8'd0;
            lol       <= 1'b0;
        end else begin
            lol <= lol_hit;
            if (lol_hit) begin
                run_cnt_q <= 8'd0;
            end else if (req_vld && (state != ST_ACQ)) begin
                if (is_rev) begin
                    run_cnt_q <= 8'd0;
                end else if (run_cnt_q != RUN_SAT) begin
                    run_cnt_q <= run_cnt_q + 8'd1;
                end
            end
        end
    end
`else
    assign lol_hit = 1'b0;
    assign lol     = 1'b0;
`endif

endmodule

// File: doc/adpll_ctrl_gen2.md
# adpll_ctrl_gen2

Second-generation ADPLL loop controller. Sits between the bang-bang phase detector (p_up/p_down) and a CODE_W-bit coarse DCO. Performs binary-search frequency acquisition, then unit-step phase tracking with a phase-lock qualifier. Optionally detects loss of lock and re-acquires without a global reset.

## Interface
- CODE_W, 7: DCO control code width, 4..10.
- STEP_INIT, 2**(CODE_W-2): first acquisition step, power of two.
- STEP_RELOCK, 4: restart step after loss of lock, power of two, at most STEP_INIT.
- LOCK_CNT, 8: consecutive reversals in TRACK required for phase_lock, 2..255.
- RUN_MAX, 6: consecutive same-direction requests that declare loss of lock, 2..255.
- phase_clk  in  1  controller clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- p_up  in  1  DCO too fast; request a decrement.
- p_down  in  1  DCO too slow; request an increment.
- dco_code  out  CODE_W  DCO coarse control code.
- freq_lock  out  1  acquisition complete (step reached 1).
- phase_lock  out  1  tracking has settled.
- polarity  out  1  one-cycle pulse on a direction reversal.
- lol  out  1  one-cycle pulse on loss of lock.
- state  out  2  0=ACQ, 1=TRACK, 2=LOCKED.

## Operation
- A valid request is exactly one of p_up or p_down high.
  - Both high or both low: no-op. Code, step, counters, dir and polarity are all held (polarity drives 0).
- dir register: last valid direction, plus a "none" flag set at reset.
  - A reversal is a valid request opposite to dir.
  - The first request after reset or relock is never a reversal.
- Code update: decrement by step on p_up, increment by step on p_down.
  - Compute in CODE_W+1 bits and saturate to 0 and 2**CODE_W-1. No wrap-around.
- ACQ:
  - On a reversal, step halves first; the halved step is applied the same cycle.
  - When the halved step equals 1, go to TRACK and set freq_lock.
- TRACK:
  - step is 1.
  - rev_cnt increments on each reversal and clears on a same-direction request.
  - When rev_cnt reaches LOCK_CNT, go to LOCKED and set phase_lock.
- run_cnt:
  - In TRACK and LOCKED, increments on each same-direction request and clears on a reversal.
  - Saturates at RUN_MAX.
- LOCKED: code tracking continues with step 1.
- Loss of lock: see Configuration.

## Timing
- Reset values:
  - dco_code=2**(CODE_W-1) (64)
  - step=STEP_INIT (32)
  - freq_lock=0, phase_lock=0, polarity=0, lol=0
  - state=ACQ, dir=none, rev_cnt=0, run_cnt=0
- All outputs are registered.
  - A request sampled at edge N is reflected on dco_code, polarity, the flags and state after edge N.
- polarity and lol are high for exactly one phase_clk cycle.
- Reset asserted mid-operation clears everything immediately, independent of phase_clk.
  - The first update after release is relative to 64.
- Saturation does not block step halving or state transitions.

## Configuration
- ADPLL_RELOCK_EN defined:
  - In TRACK or LOCKED, when run_cnt reaches RUN_MAX, pulse lol.
  - Same edge: state=ACQ, step=STEP_RELOCK, freq_lock=0, phase_lock=0, dir=none, counters cleared.
  - dco_code is left unchanged by that request.
- ADPLL_RELOCK_EN undefined:
  - No run counter; lol is tied to 0.
  - freq_lock and phase_lock are sticky until reset; LOCKED is terminal.

## Test plan
- Reset with defaults -> dco_code=64, state=0, all flags 0. Assert reset mid-search -> same values immediately.
- Acquisition: sequence down, up, down, up, down, up -> dco_code 96, 80, 88, 84, 86, 85. polarity pulses on each of the last five. freq_lock=1 and state=1 after the sixth request.
- Saturation: from reset, down x4 -> dco_code 96, 127, 127, 127, with no polarity pulse. Symmetric up x4 from 64 -> 32, 0, 0, 0.
- No-op: after reset, hold p_up=p_down=1 for 5 cycles, then 0/0 for 5 cycles -> dco_code stays 64, all flags unchanged.
- Phase lock: in TRACK at 85, alternate up/down for 8 requests -> phase_lock=1 and state=2 on the eighth. One repeat inserted at request 5 -> phase_lock needs 8 further reversals.
- Loss of lock: LOCKED at 85, 6 consecutive p_up.
  - With ADPLL_RELOCK_EN -> codes 84, 83, 82, 81, 80, then lol pulse with code held at 80, state=0, flags 0. Next p_down gives 84.
  - Without ADPLL_RELOCK_EN -> codes 84..79, lol=0, flags stay 1.
